// File: rtl/tick_timer_pkg.sv
// Shared definitions for the tick-driven countdown timer.
package tick_timer_pkg;

   // Default width of load_value / remaining (seconds).
   localparam int CNT_W_DEF      = 8;

   // Default saturation point of the tenths counter.
   localparam int TENTHS_MAX_DEF = 9;

   // Width of the tenths output.
   localparam int TENTHS_W       = 4;

   // Timer FSM state encoding.
   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE    = 2'd0;
   localparam state_t ST_RUN     = 2'd1;
   localparam state_t ST_PAUSE   = 2'd2;
   localparam state_t ST_EXPIRED = 2'd3;

endpackage

// File: rtl/edge_sync.sv
// Brings one slow square wave into the clk domain and turns each rising edge
// into a single-cycle tick. Ticks are masked for SYNC_STAGES+1 cycles after
// reset so that a level already high at release is not mistaken for an edge.
module edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic tick
);

   localparam int WARM_CYC = SYNC_STAGES + 1;
   localparam int WARM_W   = $clog2(WARM_CYC + 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;
   logic                   tick_q, tick_d;
   logic [WARM_W-1:0]      warm_q, warm_d;
   logic                   warm_done;

   // Shift the synchronizer, remember last synchronized level, detect rise.
   always_comb begin
      sync_d    = {sync_q[SYNC_STAGES-2:0], async_in};
      prev_d    = sync_q[SYNC_STAGES-1];
      warm_done = (warm_q == WARM_W'(WARM_CYC));
      warm_d    = warm_done ? warm_q : warm_q + WARM_W'(1);
      tick_d    = sync_q[SYNC_STAGES-1] & ~prev_q & warm_done;
   end

   // All edge-path flops clear on reset so warm-up restarts every time.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         tick_q <= 1'b0;
         warm_q <= '0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
         tick_q <= tick_d;
         warm_q <= warm_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/tick_timer.sv
// Loadable countdown timer driven by enable pulses derived from the divided
// 1 Hz / 10 Hz square waves. Everything runs on clk; the slow waves are data.
module tick_timer
   import tick_timer_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int SYNC_STAGES = 2,
   parameter int TENTHS_MAX  = TENTHS_MAX_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clk_1hz,
   input  logic                clk_10hz,
   input  logic                start,
   input  logic                pause,
   input  logic                cancel,
   input  logic [CNT_W-1:0]    load_value,
   output logic                tick_1hz,
   output logic                tick_10hz,
   output logic [CNT_W-1:0]    remaining,
   output logic [TENTHS_W-1:0] tenths,
   output logic                running,
   output logic                expired,
   output logic                done
);

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      rem_q, rem_d;
   logic [TENTHS_W-1:0]   tenths_q, tenths_d;
   logic                  expired_q, expired_d;

   // Tenths count stops at TENTHS_MAX rather than wrapping when the 10 Hz
   // input runs faster than the nominal divider ratio.
   function automatic logic [TENTHS_W-1:0] tenths_sat_inc(input logic [TENTHS_W-1:0] v);
      if (v >= TENTHS_W'(TENTHS_MAX)) begin
         return TENTHS_W'(TENTHS_MAX);
      end
      return v + TENTHS_W'(1);
   endfunction

   edge_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_1hz (
      .clk      (clk),
      .reset    (reset),
      .async_in (clk_1hz),
      .tick     (tick_1hz)
   );

   edge_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_10hz (
      .clk      (clk),
      .reset    (reset),
      .async_in (clk_10hz),
      .tick     (tick_10hz)
   );

   // Next-state logic; priority is cancel > start > pause > 1 Hz > 10 Hz,
   // and ticks seen outside RUN are simply dropped.
   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      tenths_d  = tenths_q;
      expired_d = 1'b0;
      if (cancel) begin
         state_d  = ST_IDLE;
         rem_d    = '0;
         tenths_d = '0;
      end else if (start) begin
         rem_d    = load_value;
         tenths_d = '0;
         if (load_value == '0) begin
            state_d   = ST_EXPIRED;
            expired_d = 1'b1;
         end else begin
            state_d = ST_RUN;
         end
      end else begin
         case (state_q)
            ST_RUN: begin
               if (pause) begin
                  state_d = ST_PAUSE;
               end else if (tick_1hz) begin
                  tenths_d = '0;
                  // Guard on <=1 so remaining can never wrap below zero.
                  if (rem_q <= CNT_W'(1)) begin
                     rem_d     = '0;
                     state_d   = ST_EXPIRED;
                     expired_d = 1'b1;
                  end else begin
                     rem_d = rem_q - CNT_W'(1);
                  end
               end else if (tick_10hz) begin
                  tenths_d = tenths_sat_inc(tenths_q);
               end
            end
            ST_PAUSE: begin
               if (!pause) begin
                  state_d = ST_RUN;
               end
            end
            ST_EXPIRED: begin
               rem_d = '0;
            end
            ST_IDLE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Timer state registers, all cleared by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         rem_q     <= '0;
         tenths_q  <= '0;
         expired_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rem_q     <= rem_d;
         tenths_q  <= tenths_d;
         expired_q <= expired_d;
      end
   end

   assign remaining = rem_q;
   assign tenths    = tenths_q;
   assign running   = (state_q == ST_RUN);
   assign done      = (state_q == ST_EXPIRED);
   assign expired   = expired_q;

endmodule
